// File: rtl/sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM encoding, instruction
// classes, controlWord field positions and the fetch control word.
package sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_B       = 3'd0,
        CLS_CBZ     = 3'd1,
        CLS_BCOND   = 3'd2,
        CLS_LDST    = 3'd3,
        CLS_ALU_REG = 3'd4,
        CLS_ALU_IMM = 3'd5,
        CLS_MOV     = 3'd6,
        CLS_UNDEF   = 3'd7
    } instr_class_e;

    localparam int unsigned CW_W     = 31;
    localparam int unsigned PSEL_HI  = 30;
    localparam int unsigned PSEL_LO  = 29;
    localparam int unsigned DA_HI    = 28;
    localparam int unsigned DA_LO    = 24;
    localparam int unsigned SA_HI    = 23;
    localparam int unsigned SA_LO    = 19;
    localparam int unsigned SB_HI    = 18;
    localparam int unsigned SB_LO    = 14;
    localparam int unsigned FSEL_HI  = 13;
    localparam int unsigned FSEL_LO  = 9;
    localparam int unsigned REGW_BIT = 8;
    localparam int unsigned RAMW_BIT = 7;
    localparam int unsigned ENMEM_BIT = 6;
    localparam int unsigned ENALU_BIT = 5;
    localparam int unsigned ENB_BIT  = 4;
    localparam int unsigned ENPC_BIT = 3;
    localparam int unsigned BSEL_BIT = 2;
    localparam int unsigned PCSEL_BIT = 1;
    localparam int unsigned SL_BIT   = 0;

    // Psel=01 selects PC <= PC + 4; every other field stays idle.
    localparam logic [CW_W-1:0] FETCH_CW = {2'b01, {(CW_W-2){1'b0}}};

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier: maps instruction bits [31:21] to the
// 3-bit decoder class used to select the per-class control decoder.
module opcode_classifier
    import sequencer_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [2:0]  instr_class
);

    instr_class_e cls;

    always_comb begin
        cls = CLS_UNDEF;
        casez (opcode)
            11'b000101?????: cls = CLS_B;
            11'b1011010????: cls = CLS_CBZ;
            11'b01010100???: cls = CLS_BCOND;
            11'b11111000010,
            11'b11111000000: cls = CLS_LDST;
            11'b10001011000,
            11'b11001011000,
            11'b10101011000,
            11'b11101011000,
            11'b10001010000,
            11'b11101010000,
            11'b10101010000,
            11'b11001010000,
            11'b11010011011,
            11'b11010011010: cls = CLS_ALU_REG;
            // Immediate forms only decode the upper 10 bits.
            11'b1001000100?,
            11'b1011000100?,
            11'b1101000100?,
            11'b1111000100?,
            11'b1001001000?,
            11'b1011001000?,
            11'b1101001000?,
            11'b1111001000?: cls = CLS_ALU_IMM;
            11'b110100101??,
            11'b111100101??: cls = CLS_MOV;
            default:         cls = CLS_UNDEF;
        endcase
    end

    assign instr_class = cls;

endmodule

// File: rtl/instruction_sequencer.sv
// Microcoded instruction sequencer: FETCH/EXEC/HALT control FSM feeding an
// external per-class decoder. Define INSTR_COUNT_EN to add retired_count.
module instruction_sequencer
    import sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] mem_data,
    input  logic        mem_ready,
    input  logic [3:0]  alu_status,
    input  logic [30:0] cw_in,
    input  logic [1:0]  ns_in,
    input  logic [63:0] k_in,
    output logic [31:0] ir,
    output logic [1:0]  state,
    output logic [3:0]  status,
    output logic [2:0]  dec_sel,
    output logic [30:0] controlWord,
    output logic [63:0] K,
`ifdef INSTR_COUNT_EN
    output logic [31:0] retired_count,
`endif
    output logic        halted
);

    seq_state_e  fsm_q, fsm_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  status_q, status_d;
    logic [2:0]  dec_sel_q, dec_sel_d;
    logic [2:0]  fetch_class;
    logic        retire;

    opcode_classifier u_classifier (
        .opcode      (mem_data[31:21]),
        .instr_class (fetch_class)
    );

    always_comb begin
        fsm_d       = fsm_q;
        ir_d        = ir_q;
        state_d     = state_q;
        status_d    = status_q;
        dec_sel_d   = dec_sel_q;
        controlWord = '0;
        K           = '0;
        retire      = 1'b0;
        case (fsm_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    controlWord = FETCH_CW;
                    ir_d        = mem_data;
                    dec_sel_d   = fetch_class;
                    state_d     = 2'b00;
                    fsm_d       = (fetch_class == 3'(CLS_UNDEF)) ? ST_HALT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                controlWord = cw_in;
                K           = k_in;
                state_d     = ns_in;
                if (cw_in[SL_BIT]) begin
                    status_d = alu_status;
                end
                if (ns_in == 2'b00) begin
                    retire = 1'b1;
                    fsm_d  = ST_FETCH;
                end
            end
            default: begin
                fsm_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fsm_q     <= ST_FETCH;
            ir_q      <= '0;
            state_q   <= '0;
            status_q  <= '0;
            dec_sel_q <= '0;
        end else begin
            fsm_q     <= fsm_d;
            ir_q      <= ir_d;
            state_q   <= state_d;
            status_q  <= status_d;
            dec_sel_q <= dec_sel_d;
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = retire ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign retired_count = count_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    assign ir      = ir_q;
    assign state   = state_q;
    assign status  = status_q;
    assign dec_sel = dec_sel_q;
    assign halted  = (fsm_q == ST_HALT);

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port mem_data, input, 32 bits: instruction word returned by instruction memory.
REQ-004 The block SHALL have the port mem_ready, input, 1 bit: mem_data is valid this cycle.
REQ-005 The block SHALL have the port alu_status, input, 4 bits: {V,C,Z,N} from the ALU.
REQ-006 The block SHALL have the ports cw_in (input, 31), ns_in (input, 2) and k_in (input, 64): controlWord, nextState and K from the selected per-class decoder.
REQ-007 The block SHALL have the ports ir (output, 32), state (output, 2) and status (output, 4): decoder inputs.
REQ-008 The block SHALL have the port dec_sel, output, 3 bits: instruction class that selects the external decoder mux.
REQ-009 The block SHALL have the ports controlWord (output, 31) and K (output, 64): drive to the datapath.
REQ-010 The block SHALL have the port halted, output, 1 bit: an undefined opcode was reached.

Function
REQ-011 The controlWord layout SHALL be {Psel[30:29], DA[28:24], SA[23:19], SB[18:14], Fsel[13:9], regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, PCsel, SL[0]}.
REQ-012 The top FSM SHALL have the states FETCH, EXEC and HALT.
REQ-013 In FETCH, controlWord SHALL be all zero while mem_ready=0, and equal to FETCH_CW (only Psel=2'b01, i.e. PC<=PC+4) in the cycle mem_ready=1.
REQ-014 In FETCH with mem_ready=1, ir SHALL load mem_data and the FSM SHALL go to EXEC with state=2'b00.
REQ-015 The classification of mem_data SHALL occur at IR load; an undefined class SHALL go to HALT instead of EXEC.
REQ-016 In EXEC, controlWord=cw_in and K=k_in, combinationally and with zero latency.
REQ-017 In EXEC, state SHALL load ns_in each cycle; ns_in==2'b00 SHALL retire the instruction and return to FETCH.
REQ-018 The status register SHALL load alu_status at the end of any EXEC cycle with cw_in[0] (SL)=1, and otherwise hold.
REQ-019 dec_sel SHALL be registered with ir, with the classes 0 B, 1 CBZ/CBNZ, 2 B.cond, 3 load/store, 4 ALU-reg, 5 ALU-imm, 6 MOVZ/MOVK, and 7 undefined.
REQ-020 In HALT, controlWord SHALL be zero, K SHALL be zero and halted=1; HALT SHALL be left only by reset.
REQ-021 Outside EXEC, K SHALL be zero.
REQ-022 mem_ready SHALL be ignored outside FETCH.

Reset
REQ-023 When reset_n=0 at an edge, the block SHALL set the state to FETCH, ir=0, state=0, status=0, dec_sel=0 and halted=0, and clear the counter.
REQ-024 Reset mid-EXEC SHALL abandon the instruction with no status update in that cycle.

Configuration
REQ-025 With INSTR_COUNT_EN defined, the block SHALL have the extra output retired_count[31:0], which increments on each EXEC-to-FETCH retire and wraps 0xFFFFFFFF to 0.
REQ-026 Without INSTR_COUNT_EN, the block SHALL have neither that port nor the counter logic.

Structure
REQ-027 The shared package sequencer_pkg SHALL hold the FSM state encoding, class codes 0-7, controlWord field bit positions, and FETCH_CW.
REQ-028 The sub-module opcode_classifier SHALL be purely combinational, mapping ir[31:21] to the 3-bit class.

Verification
REQ-029 Scenario: reset_n=0 for 2 cycles, then mem_ready=0 for 3 cycles -> controlWord=0, state=0, halted=0 throughout.
REQ-030 Scenario: mem_data=CBZ X3 (0xB4000043), mem_ready=1 -> next cycle dec_sel=1, ir=0xB4000043, and controlWord=cw_in.
REQ-031 Scenario: decoder returns ns_in=01, then 10, then 00 -> state sequence 0,1,2, and FETCH on the 4th cycle.
REQ-032 Scenario: cw_in[0]=1 with alu_status=4'b0010 -> status=0010 next cycle; with cw_in[0]=0 status holds.
REQ-033 Scenario: mem_data=0x00000000 (undefined) -> HALT, halted=1, controlWord=0 until reset.
REQ-034 Scenario: reset asserted in EXEC cycle 2 -> FETCH next cycle, status unchanged at 0, and retired_count unchanged.
